id_stage: RTL and testbench
===========================

# id_stage

Pipelined, parametrised RV32I/RV32E instruction-decode stage. It decodes the instruction, reads and writes the register file, generates immediates, and registers all results into a valid/ready pipeline register between fetch (IF) and execute (EX). It adds three behaviours: write-back bypass, stall-hold with write-back snooping, and flush.

## Interface
- XLEN, 32, datapath width in bits (≥32).
- NREG, 32, architectural register count: 32 for RV32I, 16 for RV32E.
- BYPASS, 1, 1 enables same-cycle write-back forwarding into the read ports; 0 reads the register file only.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept; equals !o_valid || i_ready.
- i_inst  in  32  instruction word.
- i_pc  in  XLEN  instruction PC.
- i_flush  in  1  kill the held and incoming instruction.
- wb_we, wb_rd, wb_data  in  1/5/XLEN  write-back port.
- o_valid  out  1  decoded bundle valid.
- i_ready  in  1  downstream accepts the bundle.
- o_pc, o_rs1_data, o_rs2_data, o_imm  out  XLEN  registered bundle.
- o_rd  out  5  destination index.
- o_alu_ctrl  out  5  ALU operation.
- o_regwrite  out  1  EX/WB must write rd.
- o_illegal  out  1  undecodable instruction.

## Operation
- Fields: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
- **ALU codes**
  - ADD 00000, SUB 10000, SLL 00100, SLT 10111, SLTU 11000, XOR 00011, SRL 00101, SRA 00110, OR 00010, AND 00001.
  - OP-IMM follows the same map. SLLI, SRLI and SRAI require funct7 to be 0000000 or 0100000 as in R-type, so SRLI maps to 00101.
  - LOAD, STORE, JALR, JAL, LUI and AUIPC use ADD. BRANCH uses SUB.
- **Illegal instructions**
  - Causes: unknown opcode, an R or shift funct7/funct3 combination outside the map, or any rs1/rs2/rd index ≥ NREG.
  - Effect: o_illegal=1, o_regwrite=0, o_alu_ctrl=00000. The bundle still flows.
- **regwrite**
  - 1 for R, OP-IMM, LOAD, JALR, LUI, AUIPC and JAL; 0 for BRANCH and STORE.
  - Forced to 0 when rd==0 or the instruction is illegal.
- **Immediates**, sign-extended to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R-type: 0.
- **Register file**
  - NREG×XLEN storage. Index 0 always reads 0; writes to index 0, or to indices ≥ NREG, are dropped.
  - A write occurs when wb_we is high.
  - With BYPASS=1: if wb_we && wb_rd==rsN && rsN!=0, the read returns wb_data in the same cycle.
- **Capture**
  - Fires when i_valid && o_ready && !i_flush.
  - Loads the whole bundle plus internal copies of rs1/rs2. The next o_valid is 1.
- **Drain**
  - o_valid && i_ready with no new capture: o_valid goes to 0 next cycle.
- **Hold (o_valid && !i_ready)**
  - The bundle stays stable except for snooping.
  - Snoop: if wb_we && wb_rd==held rsN && rsN!=0, o_rsN_data ← wb_data. This applies to rs1 and rs2 independently and needs no BYPASS gating.
- **Flush**
  - Has priority over capture and hold: o_valid←0 next cycle and the incoming instruction is discarded.
  - The register-file write from the WB port still happens.

## Timing
- **Reset** (asynchronous): o_valid=0, all bundle outputs 0, every register-file entry 0, o_illegal=0, o_regwrite=0. o_ready=1 while rst is high.
- **Latency**: 1 cycle from the capture edge to o_valid. Throughput is 1 per cycle while i_ready=1.
- **o_ready** is combinational from o_valid and i_ready. There is no skid buffer.
- **Simultaneous WB and capture**
  - BYPASS=1: the captured data reflects wb_data.
  - BYPASS=0: the captured data is the old value, and the snoop does not apply on the capture cycle.
- **Simultaneous capture and drain**: the new bundle replaces the old one; o_valid stays 1.
- **Reset mid-stall**: the bundle is lost and the register file is cleared.

## Test plan
- Reset → o_valid=0, o_ready=1. Then send ADDI x1,x0,5 (0x00500093) → next cycle o_imm=5, o_rd=1, o_alu_ctrl=00000, o_regwrite=1.
- Bypass: write x2=0x1234 via WB in the same cycle as capturing ADD x3,x2,x2 (0x002101B3), BYPASS=1 → o_rs1_data = o_rs2_data = 0x1234. Repeat with BYPASS=0 → both read 0.
- Stall snoop: hold i_ready=0 with SUB x4,x5,x6 captured, then WB x6=0xDEAD → next cycle o_rs2_data=0xDEAD, o_alu_ctrl=10000, and every other output is unchanged.
- Flush during a stall combined with i_valid=1 → o_valid=0 next cycle and the incoming instruction never appears.
- Immediates: BEQ with offset −4 → o_imm=0xFFFFFFFC, o_regwrite=0; JAL with offset 2048 → o_imm=0x800; LUI 0xABCDE → o_imm=0xABCDE000.
- Illegal: opcode 0x7F → o_illegal=1, o_regwrite=0. With NREG=16, ADD x17,x1,x1 → o_illegal=1, and a WB to x20 leaves storage unchanged.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: RV32I/RV32E instruction-decode stage with an IF->EX valid/ready
// pipeline register.
//   clk, rst           clock; asynchronous active-high reset
//   i_valid/o_ready    upstream handshake (o_ready = !o_valid || i_ready)
//   i_inst, i_pc       instruction word and its PC
//   i_flush            discards the held and the incoming instruction
//   wb_we/wb_rd/wb_data register-file write-back port
//   o_valid/i_ready    downstream handshake
//   o_pc, o_rs1_data, o_rs2_data, o_imm, o_rd, o_alu_ctrl, o_regwrite,
//   o_illegal          registered decoded bundle
module id_stage #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [XLEN-1:0] o_imm,
    output logic [4:0]      o_rd,
    output logic [4:0]      o_alu_ctrl,
    output logic            o_regwrite,
    output logic            o_illegal
);
    localparam int         IDXW   = $clog2(NREG);
    localparam logic [5:0] NREG_L = 6'(NREG);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b10000;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b10111;
    localparam logic [4:0] ALU_SLTU = 5'b11000;
    localparam logic [4:0] ALU_XOR  = 5'b00011;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b00110;
    localparam logic [4:0] ALU_OR   = 5'b00010;
    localparam logic [4:0] ALU_AND  = 5'b00001;

    logic [6:0] w_opcode;
    logic [4:0] w_rd, w_rs1, w_rs2;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = i_inst[6:0];
    assign w_rd     = i_inst[11:7];
    assign w_funct3 = i_inst[14:12];
    assign w_rs1    = i_inst[19:15];
    assign w_rs2    = i_inst[24:20];
    assign w_funct7 = i_inst[31:25];

    // ---------------- register file ----------------
    logic [XLEN-1:0] r_regs [NREG];
    logic            w_wb_ok;

    assign w_wb_ok = wb_we && (wb_rd != 5'd0) && ({1'b0, wb_rd} < NREG_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_wb_ok) begin
            r_regs[wb_rd[IDXW-1:0]] <= wb_data;
        end
    end

    logic [XLEN-1:0] w_rs1_rd, w_rs2_rd;

    always_comb begin
        w_rs1_rd = '0;
        w_rs2_rd = '0;
        if (w_rs1 != 5'd0 && {1'b0, w_rs1} < NREG_L) w_rs1_rd = r_regs[w_rs1[IDXW-1:0]];
        if (w_rs2 != 5'd0 && {1'b0, w_rs2} < NREG_L) w_rs2_rd = r_regs[w_rs2[IDXW-1:0]];
        if (BYPASS && wb_we && wb_rd == w_rs1 && w_rs1 != 5'd0) w_rs1_rd = wb_data;
        if (BYPASS && wb_we && wb_rd == w_rs2 && w_rs2 != 5'd0) w_rs2_rd = wb_data;
    end

    // ---------------- decode ----------------
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]    w_imm;
    logic [4:0]         w_alu_raw, w_alu;
    logic               w_rw_raw, w_rw;
    logic               w_bad_op, w_bad_fn, w_bad_idx, w_ill;
    logic               w_use_rs1, w_use_rs2, w_use_rd;

    always_comb begin
        w_imm32   = '0;
        w_alu_raw = ALU_ADD;
        w_rw_raw  = 1'b0;
        w_bad_op  = 1'b0;
        w_bad_fn  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_imm32  = {i_inst[31:12], 12'b0};
                w_rw_raw = 1'b1;
                w_use_rd = 1'b1;
            end
            OPC_JAL: begin
                w_imm32  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
                w_rw_raw = 1'b1;
                w_use_rd = 1'b1;
            end
            OPC_JALR, OPC_LOAD: begin
                w_imm32   = {{20{i_inst[31]}}, i_inst[31:20]};
                w_rw_raw  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
            end
            OPC_STORE: begin
                w_imm32   = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm32   = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
                w_alu_raw = ALU_SUB;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                w_imm32   = {{20{i_inst[31]}}, i_inst[31:20]};
                w_rw_raw  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                case (w_funct3)
                    3'b000: w_alu_raw = ALU_ADD;
                    3'b010: w_alu_raw = ALU_SLT;
                    3'b011: w_alu_raw = ALU_SLTU;
                    3'b100: w_alu_raw = ALU_XOR;
                    3'b110: w_alu_raw = ALU_OR;
                    3'b111: w_alu_raw = ALU_AND;
                    3'b001: begin
                        if (w_funct7 == 7'b0000000) w_alu_raw = ALU_SLL;
                        else                        w_bad_fn  = 1'b1;
                    end
                    default: begin
                        if (w_funct7 == 7'b0000000)      w_alu_raw = ALU_SRL;
                        else if (w_funct7 == 7'b0100000) w_alu_raw = ALU_SRA;
                        else                             w_bad_fn  = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                w_rw_raw  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
                case ({w_funct7, w_funct3})
                    10'b0000000_000: w_alu_raw = ALU_ADD;
                    10'b0100000_000: w_alu_raw = ALU_SUB;
                    10'b0000000_001: w_alu_raw = ALU_SLL;
                    10'b0000000_010: w_alu_raw = ALU_SLT;
                    10'b0000000_011: w_alu_raw = ALU_SLTU;
                    10'b0000000_100: w_alu_raw = ALU_XOR;
                    10'b0000000_101: w_alu_raw = ALU_SRL;
                    10'b0100000_101: w_alu_raw = ALU_SRA;
                    10'b0000000_110: w_alu_raw = ALU_OR;
                    10'b0000000_111: w_alu_raw = ALU_AND;
                    default:         w_bad_fn  = 1'b1;
                endcase
            end
            default: w_bad_op = 1'b1;
        endcase
    end

    // Only register fields the format actually uses are range-checked; the
    // same bit positions hold immediate bits in the other formats.
    assign w_bad_idx = (w_use_rs1 && {1'b0, w_rs1} >= NREG_L)
                    || (w_use_rs2 && {1'b0, w_rs2} >= NREG_L)
                    || (w_use_rd  && {1'b0, w_rd}  >= NREG_L);

    assign w_ill = w_bad_op || w_bad_fn || w_bad_idx;
    assign w_alu = w_ill ? ALU_ADD : w_alu_raw;
    assign w_rw  = w_rw_raw && !w_ill && (w_rd != 5'd0);
    assign w_imm = XLEN'(w_imm32);

    // ---------------- pipeline register ----------------
    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [4:0]      r_rd, r_alu, r_rs1_idx, r_rs2_idx;
    logic            r_regwrite, r_illegal;
    logic            w_capture;

    assign o_ready   = !r_valid || i_ready;
    assign w_capture = i_valid && o_ready && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_alu      <= '0;
            r_rs1_idx  <= '0;
            r_rs2_idx  <= '0;
            r_regwrite <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid    <= 1'b1;
            r_pc       <= i_pc;
            r_rs1_data <= w_rs1_rd;
            r_rs2_data <= w_rs2_rd;
            r_imm      <= w_imm;
            r_rd       <= w_rd;
            r_alu      <= w_alu;
            r_rs1_idx  <= w_rs1;
            r_rs2_idx  <= w_rs2;
            r_regwrite <= w_rw;
            r_illegal  <= w_ill;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            // Held bundle tracks write-backs so it is not stale when released.
            if (wb_we && wb_rd == r_rs1_idx && r_rs1_idx != 5'd0) r_rs1_data <= wb_data;
            if (wb_we && wb_rd == r_rs2_idx && r_rs2_idx != 5'd0) r_rs2_data <= wb_data;
        end
    end

    assign o_valid    = r_valid;
    assign o_pc       = r_pc;
    assign o_rs1_data = r_rs1_data;
    assign o_rs2_data = r_rs2_data;
    assign o_imm      = r_imm;
    assign o_rd       = r_rd;
    assign o_alu_ctrl = r_alu;
    assign o_regwrite = r_regwrite;
    assign o_illegal  = r_illegal;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage. Three instances share one stimulus stream:
//   dut0: NREG=32 BYPASS=1, dut1: NREG=32 BYPASS=0, dut2: NREG=16 BYPASS=1.
// A per-instance select mask gates i_valid so each vector only goes where its
// expected bundle is known.
module tb_id_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  alu;
        logic        rw;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  r_sel;
    logic        r_vin;
    logic [31:0] i_inst, i_pc, wb_data;
    logic        i_flush, wb_we, i_ready;
    logic [4:0]  wb_rd;

    logic [2:0]  o_valid_v, o_ready_v, o_rw_v, o_ill_v;
    logic [31:0] o_pc_v [3];
    logic [31:0] o_rs1_v [3];
    logic [31:0] o_rs2_v [3];
    logic [31:0] o_imm_v [3];
    logic [4:0]  o_rd_v [3];
    logic [4:0]  o_alu_v [3];

    exp_t q0[$], q1[$], q2[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic mon_pop(input int k, input exp_t act);
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        total++;
        if (!have) begin
            bad++;
            $display("FAIL dut%0d unexpected bundle pc=%h (nothing queued)", k, act.pc);
        end else if (act !== e) begin
            bad++;
            $display("FAIL dut%0d bundle got pc=%h rs1=%h rs2=%h imm=%h rd=%0d alu=%b rw=%b ill=%b required pc=%h rs1=%h rs2=%h imm=%h rd=%0d alu=%b rw=%b ill=%b",
                     k, act.pc, act.rs1, act.rs2, act.imm, act.rd, act.alu, act.rw, act.ill,
                     e.pc, e.rs1, e.rs2, e.imm, e.rd, e.alu, e.rw, e.ill);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        id_stage #(
            .XLEN  (32),
            .NREG  ((g == 2) ? 16 : 32),
            .BYPASS((g == 1) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .i_valid   (r_vin & r_sel[g]),
            .o_ready   (o_ready_v[g]),
            .i_inst    (i_inst),
            .i_pc      (i_pc),
            .i_flush   (i_flush),
            .wb_we     (wb_we),
            .wb_rd     (wb_rd),
            .wb_data   (wb_data),
            .o_valid   (o_valid_v[g]),
            .i_ready   (i_ready),
            .o_pc      (o_pc_v[g]),
            .o_rs1_data(o_rs1_v[g]),
            .o_rs2_data(o_rs2_v[g]),
            .o_imm     (o_imm_v[g]),
            .o_rd      (o_rd_v[g]),
            .o_alu_ctrl(o_alu_v[g]),
            .o_regwrite(o_rw_v[g]),
            .o_illegal (o_ill_v[g])
        );

        always @(negedge clk)
            if (!rst && o_valid_v[g] && i_ready)
                mon_pop(g, {o_pc_v[g], o_rs1_v[g], o_rs2_v[g], o_imm_v[g],
                            o_rd_v[g], o_alu_v[g], o_rw_v[g], o_ill_v[g]});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input bit [2:0] m, input logic [31:0] pc, rs1, rs2, imm,
                        input logic [4:0] rd, alu, input logic rw, ill);
        exp_t e;
        e = {pc, rs1, rs2, imm, rd, alu, rw, ill};
        if (m[0]) q0.push_back(e);
        if (m[1]) q1.push_back(e);
        if (m[2]) q2.push_back(e);
    endtask

    // One clock of stimulus; called and returns at posedge+1.
    task automatic cyc(input bit [2:0] sel, input logic v, input logic [31:0] inst, pc,
                       input logic we, input logic [4:0] rd, input logic [31:0] data,
                       input logic fl);
        r_sel   = sel;
        r_vin   = v;
        i_inst  = inst;
        i_pc    = pc;
        wb_we   = we;
        wb_rd   = rd;
        wb_data = data;
        i_flush = fl;
        @(posedge clk);
        #1;
        r_vin   = 1'b0;
        wb_we   = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic send(input bit [2:0] sel, input logic [31:0] inst, pc);
        cyc(sel, 1'b1, inst, pc, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        cyc(3'b000, 1'b0, 32'h0, 32'h0, 1'b1, rd, data, 1'b0);
    endtask

    task automatic idle();
        cyc(3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; r_sel = 3'b000; r_vin = 1'b0; i_inst = '0; i_pc = '0;
        i_flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0; i_ready = 1'b1;
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), {31'b0, o_valid_v[k]}, 32'd0);
            chk($sformatf("rst_ready%0d", k), {31'b0, o_ready_v[k]}, 32'd1);
            chk($sformatf("rst_pc%0d", k), o_pc_v[k], 32'd0);
            chk($sformatf("rst_rw%0d", k), {31'b0, o_rw_v[k]}, 32'd0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // ADDI x1,x0,5 then back-to-back ADDs (bypass vs no bypass)
        push(3'b111, 32'h100, 32'h0, 32'h0, 32'h5, 5'd1, 5'b00000, 1'b1, 1'b0);
        send(3'b111, 32'h00500093, 32'h100);
        push(3'b101, 32'h104, 32'h1234, 32'h1234, 32'h0, 5'd3, 5'b00000, 1'b1, 1'b0);
        push(3'b010, 32'h104, 32'h0, 32'h0, 32'h0, 5'd3, 5'b00000, 1'b1, 1'b0);
        cyc(3'b111, 1'b1, 32'h002101B3, 32'h104, 1'b1, 5'd2, 32'h1234, 1'b0);
        push(3'b111, 32'h108, 32'h1234, 32'h1234, 32'h0, 5'd7, 5'b00000, 1'b1, 1'b0);
        send(3'b111, 32'h002103B3, 32'h108);
        wb(5'd5, 32'h55);
        wb(5'd20, 32'hABC);

        // Stall with snoop: SUB x4,x5,x6 held, then x6 written
        i_ready = 1'b0;
        push(3'b111, 32'h10C, 32'h55, 32'hDEAD, 32'h0, 5'd4, 5'b10000, 1'b1, 1'b0);
        send(3'b111, 32'h40628233, 32'h10C);
        wb(5'd6, 32'hDEAD);
        idle();
        chk("stall_ready0", {31'b0, o_ready_v[0]}, 32'd0);
        chk("snoop_rs2_nobypass", o_rs2_v[1], 32'hDEAD);
        i_ready = 1'b1;
        idle();

        // Flush during a stall with a new instruction offered; WB still lands
        i_ready = 1'b0;
        send(3'b111, 32'h00100413, 32'h110);
        cyc(3'b111, 1'b1, 32'h00200493, 32'h114, 1'b1, 5'd10, 32'h77, 1'b1);
        for (int k = 0; k < 3; k++)
            chk($sformatf("flush_valid%0d", k), {31'b0, o_valid_v[k]}, 32'd0);
        i_ready = 1'b1;
        idle();
        idle();
        push(3'b111, 32'h118, 32'h77, 32'h0, 32'h0, 5'd11, 5'b00000, 1'b1, 1'b0);
        send(3'b111, 32'h000505B3, 32'h118);

        // Immediates: BEQ -4, JAL +2048, LUI 0xABCDE
        push(3'b011, 32'h11C, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd29, 5'b10000, 1'b0, 1'b0);
        send(3'b011, 32'hFE000EE3, 32'h11C);
        push(3'b111, 32'h120, 32'h0, 32'h0, 32'h800, 5'd1, 5'b00000, 1'b1, 1'b0);
        send(3'b111, 32'h001000EF, 32'h120);
        push(3'b011, 32'h124, 32'h0, 32'h0, 32'hABCDE000, 5'd5, 5'b00000, 1'b1, 1'b0);
        send(3'b011, 32'hABCDE2B7, 32'h124);

        // Illegal opcode, illegal R funct7, shift-immediate mapping
        push(3'b111, 32'h128, 32'h0, 32'h0, 32'h0, 5'd0, 5'b00000, 1'b0, 1'b1);
        send(3'b111, 32'h0000007F, 32'h128);
        push(3'b111, 32'h12C, 32'h1234, 32'h1234, 32'h0, 5'd3, 5'b00000, 1'b0, 1'b1);
        send(3'b111, 32'h022101B3, 32'h12C);
        push(3'b111, 32'h130, 32'h0, 32'h0, 32'h403, 5'd1, 5'b00110, 1'b1, 1'b0);
        send(3'b111, 32'h4030D093, 32'h130);
        push(3'b111, 32'h134, 32'h0, 32'h0, 32'h3, 5'd1, 5'b00101, 1'b1, 1'b0);
        send(3'b111, 32'h0030D093, 32'h134);
        push(3'b111, 32'h138, 32'h0, 32'h0, 32'h403, 5'd1, 5'b00000, 1'b0, 1'b1);
        send(3'b111, 32'h40309093, 32'h138);

        // More R-type codes and a store
        push(3'b111, 32'h13C, 32'h55, 32'h1234, 32'h0, 5'd15, 5'b00010, 1'b1, 1'b0);
        send(3'b111, 32'h0022E7B3, 32'h13C);
        push(3'b111, 32'h140, 32'h55, 32'h1234, 32'h0, 5'd15, 5'b11000, 1'b1, 1'b0);
        send(3'b111, 32'h0022B7B3, 32'h140);
        push(3'b111, 32'h144, 32'h1234, 32'h55, 32'h8, 5'd8, 5'b00000, 1'b0, 1'b0);
        send(3'b111, 32'h00512423, 32'h144);

        // RV32E: x17 illegal; WB to x20 must not alias onto x4
        push(3'b011, 32'h148, 32'h0, 32'h0, 32'h0, 5'd17, 5'b00000, 1'b1, 1'b0);
        push(3'b100, 32'h148, 32'h0, 32'h0, 32'h0, 5'd17, 5'b00000, 1'b0, 1'b1);
        send(3'b111, 32'h001088B3, 32'h148);
        push(3'b111, 32'h14C, 32'h0, 32'h0, 32'h0, 5'd12, 5'b00000, 1'b1, 1'b0);
        send(3'b111, 32'h00420633, 32'h14C);
        push(3'b011, 32'h150, 32'hABC, 32'h0, 32'h0, 5'd13, 5'b00000, 1'b1, 1'b0);
        send(3'b011, 32'h000A06B3, 32'h150);

        // x0 write-back is neither stored nor forwarded
        push(3'b111, 32'h154, 32'h0, 32'h0, 32'h0, 5'd14, 5'b00000, 1'b1, 1'b0);
        cyc(3'b111, 1'b1, 32'h00000733, 32'h154, 1'b1, 5'd0, 32'hFFFF, 1'b0);
        idle();

        // Reset in the middle of a stall
        i_ready = 1'b0;
        send(3'b111, 32'h002101B3, 32'h200);
        idle();
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("midrst_valid%0d", k), {31'b0, o_valid_v[k]}, 32'd0);
            chk($sformatf("midrst_ready%0d", k), {31'b0, o_ready_v[k]}, 32'd1);
            chk($sformatf("midrst_pc%0d", k), o_pc_v[k], 32'd0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        i_ready = 1'b1;
        push(3'b111, 32'h204, 32'h0, 32'h0, 32'h0, 5'd3, 5'b00000, 1'b1, 1'b0);
        send(3'b111, 32'h002101B3, 32'h204);
        idle();
        idle();
        idle();

        chk("q0_left", q0.size(), 32'd0);
        chk("q1_left", q1.size(), 32'd0);
        chk("q2_left", q2.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
